s1_s2_pipe_reg: RTL and testbench
=================================

Name: s1_s2_pipe_reg

Overview:
- Stage-1 to stage-2 pipeline register of the pipelined datapath.
- Captures decoded operands and control from stage 1 and presents them as S2_* signals to the stage-2 operand mux and ALU.
- Supports stall (hold) and flush (bubble).
- Applies write-through bypass from stage 3 writeback, both at capture and to held contents during a stall, so S2 operands are never stale.

Parameters:
- DATA_W, 32, operand/result width
- IMM_W, 16, immediate width
- REG_ADDR_W, 5, register index width
- ALUOP_W, 3, ALU opcode width
- ZERO_REG_HARDWIRED, 1, when 1 index 0 is never bypassed

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- S1_Valid  in  1  stage 1 holds a real instruction
- S1_ReadSelect1  in  REG_ADDR_W  source register A index
- S1_ReadSelect2  in  REG_ADDR_W  source register B index
- S1_ReadData1  in  DATA_W  regfile read A
- S1_ReadData2  in  DATA_W  regfile read B
- S1_Imm  in  IMM_W  immediate field
- S1_DataSource  in  1  1 = immediate operand
- S1_ALUOp  in  ALUOP_W  ALU opcode
- S1_WriteSelect  in  REG_ADDR_W  destination index
- S1_WriteEnable  in  1  instruction writes regfile
- S3_WriteEnable  in  1  writeback active this cycle
- S3_WriteSelect  in  REG_ADDR_W  writeback destination
- S3_ALUOut  in  DATA_W  writeback data
- Stall  in  1  hold S2 contents
- Flush  in  1  replace S2 contents with bubble
- S2_Valid  out  1  S2 holds a real instruction
- S2_ReadSelect1, S2_ReadSelect2  out  REG_ADDR_W  registered source indices
- S2_ReadData1, S2_ReadData2  out  DATA_W  operands to stage 2
- S2_Imm  out  IMM_W  immediate
- S2_DataSource  out  1  operand select
- S2_ALUOp  out  ALUOP_W  opcode
- S2_WriteSelect  out  REG_ADDR_W  destination
- S2_WriteEnable  out  1  gated write enable
- S2_StallCount  out  32  stall-cycle counter (optional feature)
- S2_FlushCount  out  32  flush-cycle counter (optional feature)

Behaviour:
- Reset: while reset_n=0, every output is 0 immediately, with no clock required. Release is synchronous to the next clk edge.
- Latency: 1 cycle S1→S2 on each rising edge.
- Priority per edge: Flush > Stall > load.
- Flush:
  - S2_Valid, S2_WriteEnable, S2_DataSource, S2_ALUOp, S2_Imm, S2_ReadData*, S2_ReadSelect* and S2_WriteSelect all load 0.
  - Flush together with Stall still produces a bubble.
- Stall (no Flush): all fields hold, except the hold-bypass below.
- Load (neither asserted):
  - All S2_* load the matching S1_* fields.
  - S2_WriteEnable loads S1_WriteEnable & S1_Valid.
- Capture bypass, per operand n ∈ {1,2}:
  - Condition: S3_WriteEnable=1, S3_WriteSelect==S1_ReadSelectn, and not (ZERO_REG_HARDWIRED and index==0).
  - Effect: S2_ReadDatan loads S3_ALUOut instead of S1_ReadDatan.
  - Both operands may bypass in the same cycle.
- Hold bypass: during Stall, if S3_WriteEnable=1 and S3_WriteSelect==S2_ReadSelectn (same zero rule), S2_ReadDatan loads S3_ALUOut. Other fields hold.
- Bypass is independent of S1_Valid and S2_Valid. Data in an invalid slot is don't-care downstream, but must follow the rules above.
- No combinational path from any input to any output.
- Reset asserted mid-stall or mid-flush: outputs clear immediately, and no state survives.

Optional Feature:
- Macro: S2_PERF_CNT_EN.
- Defined:
  - S2_StallCount increments on each edge with Stall=1 and Flush=0.
  - S2_FlushCount increments on each edge with Flush=1.
  - Both are 32-bit, wrap 0xFFFFFFFF→0, and clear on reset.
- Undefined: both ports driven constant 0 and no counter flops are synthesised.

Decomposition:
- Shared package: DATA_W, IMM_W, REG_ADDR_W and ALUOP_W constants; ALU opcode enumeration; a typedef for the S2 bundle (valid, selects, data, imm, datasource, aluop, writeselect, writeenable).
- One natural sub-module, s2_bypass_sel: given index, candidate data, S3_WriteEnable, S3_WriteSelect and S3_ALUOut, returns the selected data. Instantiated four times: capture and hold, for each operand.

Test Plan:
- Reset: assert reset_n=0 mid-cycle with S2 loaded → all S2_* read 0 before the next edge; release, load S1_ReadData1=0x12345678 → S2_ReadData1=0x12345678 one edge later.
- Plain load: S1_Imm=0xBEEF, S1_DataSource=1, S1_ALUOp=3, S1_Valid=1, S1_WriteEnable=1 → next edge S2_Imm=0xBEEF, S2_DataSource=1, S2_ALUOp=3, S2_WriteEnable=1. With S1_Valid=0 → S2_WriteEnable=0.
- Capture bypass: S1_ReadSelect1=S1_ReadSelect2=7, S1_ReadData*=0x1, S3_WriteEnable=1, S3_WriteSelect=7, S3_ALUOut=0xCAFE0000 → both S2_ReadData=0xCAFE0000. Repeat with index 0 → S2_ReadData=0x1.
- Hold bypass: S2 holds ReadSelect2=4; Stall=1 for 3 cycles; S3 writes r4=0x55 in cycle 2 → S2_ReadData2=0x55 from then on; all other fields unchanged.
- Flush priority: Stall=1 and Flush=1 on the same edge with valid S2 → S2_Valid=0, S2_WriteEnable=0, S2_ReadData1=0.
- With S2_PERF_CNT_EN: 5 stall edges and 2 flush edges (1 coincident with Stall) → S2_StallCount=4, S2_FlushCount=2. Without the macro → both read 0.

Source files
------------

// File: rtl/s1_s2_pipe_reg_pkg.sv
// Shared widths, ALU opcode encoding and the S2 bundle layout for the
// stage-1 to stage-2 pipeline register.
package s1_s2_pipe_reg_pkg;

    localparam int DATA_W     = 32;
    localparam int IMM_W      = 16;
    localparam int REG_ADDR_W = 5;
    localparam int ALUOP_W    = 3;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] read_select1;
        logic [REG_ADDR_W-1:0] read_select2;
        logic [DATA_W-1:0]     read_data1;
        logic [DATA_W-1:0]     read_data2;
        logic [IMM_W-1:0]      imm;
        logic                  data_source;
        alu_op_e               alu_op;
        logic [REG_ADDR_W-1:0] write_select;
        logic                  write_enable;
    } s2_bundle_t;

endpackage

// File: rtl/s2_bypass_sel.sv
// Write-through bypass select: picks the stage-3 writeback value when it
// targets the operand's register, otherwise passes the candidate through.
module s2_bypass_sel #(
    parameter int DATA_W             = 32,
    parameter int REG_ADDR_W         = 5,
    parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
    input  logic [REG_ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0]     cand_data,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_sel,
    input  logic [DATA_W-1:0]     wb_data,
    output logic [DATA_W-1:0]     sel_data
);

    logic hit;

    // r0 reads as constant, so a writeback aimed at it must never leak through
    assign hit      = wb_en && (wb_sel == idx) && !(ZERO_REG_HARDWIRED && (idx == '0));
    assign sel_data = hit ? wb_data : cand_data;

endmodule

// File: rtl/s1_s2_pipe_reg.sv
// Stage-1 to stage-2 pipeline register with stall, flush and stage-3
// write-through bypass. Optional stall/flush counters under S2_PERF_CNT_EN.
module s1_s2_pipe_reg
    import s1_s2_pipe_reg_pkg::*;
#(
    parameter int DATA_W             = s1_s2_pipe_reg_pkg::DATA_W,
    parameter int IMM_W              = s1_s2_pipe_reg_pkg::IMM_W,
    parameter int REG_ADDR_W         = s1_s2_pipe_reg_pkg::REG_ADDR_W,
    parameter int ALUOP_W            = s1_s2_pipe_reg_pkg::ALUOP_W,
    parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  S1_Valid,
    input  logic [REG_ADDR_W-1:0] S1_ReadSelect1,
    input  logic [REG_ADDR_W-1:0] S1_ReadSelect2,
    input  logic [DATA_W-1:0]     S1_ReadData1,
    input  logic [DATA_W-1:0]     S1_ReadData2,
    input  logic [IMM_W-1:0]      S1_Imm,
    input  logic                  S1_DataSource,
    input  logic [ALUOP_W-1:0]    S1_ALUOp,
    input  logic [REG_ADDR_W-1:0] S1_WriteSelect,
    input  logic                  S1_WriteEnable,
    input  logic                  S3_WriteEnable,
    input  logic [REG_ADDR_W-1:0] S3_WriteSelect,
    input  logic [DATA_W-1:0]     S3_ALUOut,
    input  logic                  Stall,
    input  logic                  Flush,
    output logic                  S2_Valid,
    output logic [REG_ADDR_W-1:0] S2_ReadSelect1,
    output logic [REG_ADDR_W-1:0] S2_ReadSelect2,
    output logic [DATA_W-1:0]     S2_ReadData1,
    output logic [DATA_W-1:0]     S2_ReadData2,
    output logic [IMM_W-1:0]      S2_Imm,
    output logic                  S2_DataSource,
    output logic [ALUOP_W-1:0]    S2_ALUOp,
    output logic [REG_ADDR_W-1:0] S2_WriteSelect,
    output logic                  S2_WriteEnable,
    output logic [31:0]           S2_StallCount,
    output logic [31:0]           S2_FlushCount
);

    logic [DATA_W-1:0] cap_data1_p1, cap_data2_p1;
    logic [DATA_W-1:0] hold_data1_p2, hold_data2_p2;

    s2_bypass_sel #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED))
    u_cap1 (
        .idx(S1_ReadSelect1), .cand_data(S1_ReadData1),
        .wb_en(S3_WriteEnable), .wb_sel(S3_WriteSelect), .wb_data(S3_ALUOut),
        .sel_data(cap_data1_p1)
    );

    s2_bypass_sel #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED))
    u_cap2 (
        .idx(S1_ReadSelect2), .cand_data(S1_ReadData2),
        .wb_en(S3_WriteEnable), .wb_sel(S3_WriteSelect), .wb_data(S3_ALUOut),
        .sel_data(cap_data2_p1)
    );

    // Held operands keep refreshing from writeback so a long stall never goes stale
    s2_bypass_sel #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED))
    u_hold1 (
        .idx(S2_ReadSelect1), .cand_data(S2_ReadData1),
        .wb_en(S3_WriteEnable), .wb_sel(S3_WriteSelect), .wb_data(S3_ALUOut),
        .sel_data(hold_data1_p2)
    );

    s2_bypass_sel #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED))
    u_hold2 (
        .idx(S2_ReadSelect2), .cand_data(S2_ReadData2),
        .wb_en(S3_WriteEnable), .wb_sel(S3_WriteSelect), .wb_data(S3_ALUOut),
        .sel_data(hold_data2_p2)
    );

    // Stage 1 -> stage 2 boundary
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || Flush) begin
            S2_Valid       <= 1'b0;
            S2_ReadSelect1 <= '0;
            S2_ReadSelect2 <= '0;
            S2_ReadData1   <= '0;
            S2_ReadData2   <= '0;
            S2_Imm         <= '0;
            S2_DataSource  <= 1'b0;
            S2_ALUOp       <= '0;
            S2_WriteSelect <= '0;
            S2_WriteEnable <= 1'b0;
        end else if (Stall) begin
            S2_ReadData1 <= hold_data1_p2;
            S2_ReadData2 <= hold_data2_p2;
        end else begin
            S2_Valid       <= S1_Valid;
            S2_ReadSelect1 <= S1_ReadSelect1;
            S2_ReadSelect2 <= S1_ReadSelect2;
            S2_ReadData1   <= cap_data1_p1;
            S2_ReadData2   <= cap_data2_p1;
            S2_Imm         <= S1_Imm;
            S2_DataSource  <= S1_DataSource;
            S2_ALUOp       <= S1_ALUOp;
            S2_WriteSelect <= S1_WriteSelect;
            S2_WriteEnable <= S1_WriteEnable & S1_Valid;
        end
    end

`ifdef S2_PERF_CNT_EN
    logic [31:0] stall_cnt_p2, flush_cnt_p2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_p2 <= '0;
            flush_cnt_p2 <= '0;
        end else if (Flush) begin
            flush_cnt_p2 <= flush_cnt_p2 + 32'd1;
        end else if (Stall) begin
            stall_cnt_p2 <= stall_cnt_p2 + 32'd1;
        end
    end

    assign S2_StallCount = stall_cnt_p2;
    assign S2_FlushCount = flush_cnt_p2;
`else
    assign S2_StallCount = '0;
    assign S2_FlushCount = '0;
`endif

endmodule

// File: tb/tb_s1_s2_pipe_reg.sv
// Directed bench for s1_s2_pipe_reg: reset, load, capture/hold bypass,
// flush priority and the optional S2_PERF_CNT_EN counters.
module tb_s1_s2_pipe_reg;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        S1_Valid;
    logic [4:0]  S1_ReadSelect1, S1_ReadSelect2;
    logic [31:0] S1_ReadData1, S1_ReadData2;
    logic [15:0] S1_Imm;
    logic        S1_DataSource;
    logic [2:0]  S1_ALUOp;
    logic [4:0]  S1_WriteSelect;
    logic        S1_WriteEnable;
    logic        S3_WriteEnable;
    logic [4:0]  S3_WriteSelect;
    logic [31:0] S3_ALUOut;
    logic        Stall, Flush;
    logic        S2_Valid;
    logic [4:0]  S2_ReadSelect1, S2_ReadSelect2;
    logic [31:0] S2_ReadData1, S2_ReadData2;
    logic [15:0] S2_Imm;
    logic        S2_DataSource;
    logic [2:0]  S2_ALUOp;
    logic [4:0]  S2_WriteSelect;
    logic        S2_WriteEnable;
    logic [31:0] S2_StallCount, S2_FlushCount;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] exp_st, exp_fl;

    s1_s2_pipe_reg dut (
        .clk(clk), .reset_n(reset_n),
        .S1_Valid(S1_Valid), .S1_ReadSelect1(S1_ReadSelect1), .S1_ReadSelect2(S1_ReadSelect2),
        .S1_ReadData1(S1_ReadData1), .S1_ReadData2(S1_ReadData2), .S1_Imm(S1_Imm),
        .S1_DataSource(S1_DataSource), .S1_ALUOp(S1_ALUOp), .S1_WriteSelect(S1_WriteSelect),
        .S1_WriteEnable(S1_WriteEnable), .S3_WriteEnable(S3_WriteEnable),
        .S3_WriteSelect(S3_WriteSelect), .S3_ALUOut(S3_ALUOut), .Stall(Stall), .Flush(Flush),
        .S2_Valid(S2_Valid), .S2_ReadSelect1(S2_ReadSelect1), .S2_ReadSelect2(S2_ReadSelect2),
        .S2_ReadData1(S2_ReadData1), .S2_ReadData2(S2_ReadData2), .S2_Imm(S2_Imm),
        .S2_DataSource(S2_DataSource), .S2_ALUOp(S2_ALUOp), .S2_WriteSelect(S2_WriteSelect),
        .S2_WriteEnable(S2_WriteEnable), .S2_StallCount(S2_StallCount),
        .S2_FlushCount(S2_FlushCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        S1_Valid = 0; S1_ReadSelect1 = 0; S1_ReadSelect2 = 0;
        S1_ReadData1 = 0; S1_ReadData2 = 0; S1_Imm = 0; S1_DataSource = 0;
        S1_ALUOp = 0; S1_WriteSelect = 0; S1_WriteEnable = 0;
        S3_WriteEnable = 0; S3_WriteSelect = 0; S3_ALUOut = 0;
        Stall = 0; Flush = 0;
        #1;
        chk("rst_valid", {31'd0, S2_Valid}, 32'd0);
        chk("rst_rd1", S2_ReadData1, 32'd0);

        // plain load of a full instruction
        reset_n = 1'b1;
        S1_Valid = 1; S1_ReadSelect1 = 5'd3; S1_ReadSelect2 = 5'd9;
        S1_ReadData1 = 32'h12345678; S1_ReadData2 = 32'hA5A5A5A5;
        S1_Imm = 16'hBEEF; S1_DataSource = 1; S1_ALUOp = 3'd3;
        S1_WriteSelect = 5'd12; S1_WriteEnable = 1;
        step();
        chk("ld_valid", {31'd0, S2_Valid}, 32'd1);
        chk("ld_rs1", {27'd0, S2_ReadSelect1}, 32'd3);
        chk("ld_rs2", {27'd0, S2_ReadSelect2}, 32'd9);
        chk("ld_rd1", S2_ReadData1, 32'h12345678);
        chk("ld_rd2", S2_ReadData2, 32'hA5A5A5A5);
        chk("ld_imm", {16'd0, S2_Imm}, 32'h0000BEEF);
        chk("ld_ds", {31'd0, S2_DataSource}, 32'd1);
        chk("ld_aluop", {29'd0, S2_ALUOp}, 32'd3);
        chk("ld_ws", {27'd0, S2_WriteSelect}, 32'd12);
        chk("ld_we", {31'd0, S2_WriteEnable}, 32'd1);

        // asynchronous reset mid-cycle with S2 loaded
        reset_n = 1'b0;
        #2;
        chk("arst_valid", {31'd0, S2_Valid}, 32'd0);
        chk("arst_rd1", S2_ReadData1, 32'd0);
        chk("arst_imm", {16'd0, S2_Imm}, 32'd0);
        chk("arst_we", {31'd0, S2_WriteEnable}, 32'd0);
        chk("arst_aluop", {29'd0, S2_ALUOp}, 32'd0);
        chk("arst_ws", {27'd0, S2_WriteSelect}, 32'd0);
        reset_n = 1'b1;
        step();
        chk("rel_rd1", S2_ReadData1, 32'h12345678);

        // invalid slot suppresses write enable
        S1_Valid = 0;
        step();
        chk("inv_we", {31'd0, S2_WriteEnable}, 32'd0);
        chk("inv_valid", {31'd0, S2_Valid}, 32'd0);

        // capture bypass on both operands
        S1_Valid = 1; S1_ReadSelect1 = 5'd7; S1_ReadSelect2 = 5'd7;
        S1_ReadData1 = 32'h1; S1_ReadData2 = 32'h1;
        S3_WriteEnable = 1; S3_WriteSelect = 5'd7; S3_ALUOut = 32'hCAFE0000;
        step();
        chk("cap_rd1", S2_ReadData1, 32'hCAFE0000);
        chk("cap_rd2", S2_ReadData2, 32'hCAFE0000);

        // index 0 is never bypassed
        S1_ReadSelect1 = 5'd0; S1_ReadSelect2 = 5'd0; S3_WriteSelect = 5'd0;
        step();
        chk("r0_rd1", S2_ReadData1, 32'h1);
        chk("r0_rd2", S2_ReadData2, 32'h1);

        // only the matching operand bypasses
        S1_ReadSelect1 = 5'd7; S1_ReadSelect2 = 5'd8; S3_WriteSelect = 5'd8;
        step();
        chk("one_rd1", S2_ReadData1, 32'h1);
        chk("one_rd2", S2_ReadData2, 32'hCAFE0000);

        // no bypass without writeback enable
        S1_ReadSelect2 = 5'd7; S3_WriteSelect = 5'd7; S3_WriteEnable = 0;
        step();
        chk("nowb_rd1", S2_ReadData1, 32'h1);

        // hold bypass across a three-cycle stall
        S1_ReadSelect1 = 5'd2; S1_ReadSelect2 = 5'd4;
        S1_ReadData1 = 32'h11; S1_ReadData2 = 32'h22;
        S1_Imm = 16'h1234; S1_ALUOp = 3'd5; S1_WriteSelect = 5'd6;
        step();
        Stall = 1;
        S1_ReadSelect1 = 5'd31; S1_ReadSelect2 = 5'd31;
        S1_ReadData1 = 32'hFFFFFFFF; S1_ReadData2 = 32'hFFFFFFFF;
        S1_Imm = 16'h0; S1_ALUOp = 3'd0; S1_WriteSelect = 5'd0; S1_Valid = 0;
        step();
        chk("st1_rd2", S2_ReadData2, 32'h22);
        chk("st1_imm", {16'd0, S2_Imm}, 32'h1234);
        S3_WriteEnable = 1; S3_WriteSelect = 5'd4; S3_ALUOut = 32'h55;
        step();
        chk("st2_rd2", S2_ReadData2, 32'h55);
        chk("st2_rd1", S2_ReadData1, 32'h11);
        S3_WriteEnable = 0;
        step();
        chk("st3_rd2", S2_ReadData2, 32'h55);
        chk("st3_aluop", {29'd0, S2_ALUOp}, 32'd5);
        chk("st3_ws", {27'd0, S2_WriteSelect}, 32'd6);
        chk("st3_valid", {31'd0, S2_Valid}, 32'd1);
        chk("st3_rs2", {27'd0, S2_ReadSelect2}, 32'd4);

        // flush wins over stall
        Flush = 1;
        step();
        chk("fl_valid", {31'd0, S2_Valid}, 32'd0);
        chk("fl_we", {31'd0, S2_WriteEnable}, 32'd0);
        chk("fl_rd1", S2_ReadData1, 32'd0);
        chk("fl_rs2", {27'd0, S2_ReadSelect2}, 32'd0);
        Flush = 0; Stall = 0;

        // counters: 5 stall edges, one also flushed, then one lone flush
        reset_n = 1'b0;
        #2;
        chk("cnt_rst_st", S2_StallCount, 32'd0);
        chk("cnt_rst_fl", S2_FlushCount, 32'd0);
        reset_n = 1'b1;
        Stall = 1;
        step(); step();
        Flush = 1;
        step();
        Flush = 0;
        step(); step();
        Stall = 0; Flush = 1;
        step();
        Flush = 0;
`ifdef S2_PERF_CNT_EN
        exp_st = 32'd4;
        exp_fl = 32'd2;
`else
        exp_st = 32'd0;
        exp_fl = 32'd0;
`endif
        chk("cnt_stall", S2_StallCount, exp_st);
        chk("cnt_flush", S2_FlushCount, exp_fl);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
